// File: rtl/if_fetch_pred.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_pred
// Purpose  : IF stage PC register with direct-mapped BTB and 2-bit counters.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_pred #(
    parameter int          BTB_ENTRIES = 16,
    parameter int          IDX_W       = 4,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCWrite,
    input  logic        ex_branch,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_redirect,
    input  logic [31:0] ex_redirect_pc,
    output logic [31:0] pc_f,
    output logic [31:0] npc_f,
    output logic        br_pred_f,
    output logic        btb_hit
);

    localparam int TAG_W = 32 - IDX_W - 2;

    logic [31:0]      pc_f_q;
    logic [31:0]      pc_f_d;
    logic             valid_q  [BTB_ENTRIES];
    logic [1:0]       cnt_q    [BTB_ENTRIES];
    logic [TAG_W-1:0] tag_q    [BTB_ENTRIES];
    logic [31:0]      target_q [BTB_ENTRIES];

    logic [IDX_W-1:0] w_rd_idx;
    logic [TAG_W-1:0] w_rd_tag;
    logic [IDX_W-1:0] w_wr_idx;
    logic [TAG_W-1:0] w_wr_tag;
    logic             w_wr_hit;
    logic [1:0]       w_cnt_upd;
    logic             w_unused_ex_pc_lsb;

    // Byte-offset bits of the resolved PC play no part in indexing.
    assign w_unused_ex_pc_lsb = ^ex_pc[1:0];

    assign w_rd_idx = pc_f_q[IDX_W+1:2];
    assign w_rd_tag = pc_f_q[31:IDX_W+2];
    assign w_wr_idx = ex_pc[IDX_W+1:2];
    assign w_wr_tag = ex_pc[31:IDX_W+2];

    always_comb begin
        btb_hit   = valid_q[w_rd_idx] && (tag_q[w_rd_idx] == w_rd_tag);
        br_pred_f = btb_hit && cnt_q[w_rd_idx][1];
        npc_f     = br_pred_f ? target_q[w_rd_idx] : pc_f_q + 32'd4;
        pc_f      = pc_f_q;
    end

    always_comb begin
        pc_f_d = npc_f;
        if (ex_redirect) begin
            pc_f_d = ex_redirect_pc;
        end else if (!PCWrite) begin
            pc_f_d = pc_f_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f_q <= RESET_PC;
        end else begin
            pc_f_q <= pc_f_d;
        end
    end

    assign w_wr_hit = valid_q[w_wr_idx] && (tag_q[w_wr_idx] == w_wr_tag);

    always_comb begin
        w_cnt_upd = cnt_q[w_wr_idx];
        if (ex_taken && (cnt_q[w_wr_idx] != 2'b11)) begin
            w_cnt_upd = cnt_q[w_wr_idx] + 2'b01;
        end else if (!ex_taken && (cnt_q[w_wr_idx] != 2'b00)) begin
            w_cnt_upd = cnt_q[w_wr_idx] - 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= 2'b01;
            end
        end else if (ex_branch) begin
            if (w_wr_hit) begin
                cnt_q[w_wr_idx] <= w_cnt_upd;
            end else if (ex_taken) begin
                valid_q[w_wr_idx] <= 1'b1;
                cnt_q[w_wr_idx]   <= 2'b10;
            end
        end
    end

    // Tag/target have no reset so they can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (!rst && ex_branch && ex_taken) begin
            tag_q[w_wr_idx]    <= w_wr_tag;
            target_q[w_wr_idx] <= ex_target;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_pred.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_if_fetch_pred
// Purpose  : Self-checking bench for if_fetch_pred against a behavioural BTB.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_pred;

    localparam int IDX_W = 4;
    localparam int N     = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PCWrite = 1'b1;
    logic        ex_branch = 1'b0;
    logic [31:0] ex_pc = '0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_target = '0;
    logic        ex_redirect = 1'b0;
    logic [31:0] ex_redirect_pc = '0;
    logic [31:0] pc_f;
    logic [31:0] npc_f;
    logic        br_pred_f;
    logic        btb_hit;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    if_fetch_pred #(
        .BTB_ENTRIES(N),
        .IDX_W      (IDX_W),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .PCWrite       (PCWrite),
        .ex_branch     (ex_branch),
        .ex_pc         (ex_pc),
        .ex_taken      (ex_taken),
        .ex_target     (ex_target),
        .ex_redirect   (ex_redirect),
        .ex_redirect_pc(ex_redirect_pc),
        .pc_f          (pc_f),
        .npc_f         (npc_f),
        .br_pred_f     (br_pred_f),
        .btb_hit       (btb_hit)
    );

    // Reference: table of entries keyed by word index, counter as plain int.
    bit          m_valid [N];
    logic [31:0] m_upper [N];
    logic [31:0] m_tgt   [N];
    int          m_cnt   [N];
    logic [31:0] m_pc;

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) % N);
    endfunction

    function automatic logic [31:0] upper_of(input logic [31:0] a);
        return a >> (IDX_W + 2);
    endfunction

    function automatic bit m_hit();
        return m_valid[idx_of(m_pc)] && (m_upper[idx_of(m_pc)] == upper_of(m_pc));
    endfunction

    function automatic bit m_pred();
        return m_hit() && (m_cnt[idx_of(m_pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_npc();
        logic [32:0] seq;
        seq = {1'b0, m_pc} + 33'd4;
        return m_pred() ? m_tgt[idx_of(m_pc)] : seq[31:0];
    endfunction

    function automatic int sat(input int c, input bit up);
        if (up) return (c >= 3) ? 3 : c + 1;
        return (c <= 0) ? 0 : c - 1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_valid[i] <= 1'b0;
                m_cnt[i]   <= 1;
            end
            m_pc <= 32'h0;
        end else begin
            m_pc <= ex_redirect ? ex_redirect_pc : (!PCWrite ? m_pc : m_npc());
            if (ex_branch) begin
                if (m_valid[idx_of(ex_pc)] && (m_upper[idx_of(ex_pc)] == upper_of(ex_pc))) begin
                    m_cnt[idx_of(ex_pc)] <= sat(m_cnt[idx_of(ex_pc)], ex_taken);
                    if (ex_taken) m_tgt[idx_of(ex_pc)] <= ex_target;
                end else if (ex_taken) begin
                    m_valid[idx_of(ex_pc)] <= 1'b1;
                    m_upper[idx_of(ex_pc)] <= upper_of(ex_pc);
                    m_tgt[idx_of(ex_pc)]   <= ex_target;
                    m_cnt[idx_of(ex_pc)]   <= 2;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_pc_f", pc_f, m_pc);
            check("model_btb_hit", {31'b0, btb_hit}, {31'b0, m_hit()});
            check("model_br_pred_f", {31'b0, br_pred_f}, {31'b0, m_pred()});
            check("model_npc_f", npc_f, m_npc());
        end
    end

    task automatic exp4(input string nm, input logic [31:0] pc, input bit hit,
                        input bit pred, input logic [31:0] npc);
        check({nm, "_pc"}, pc_f, pc);
        check({nm, "_hit"}, {31'b0, btb_hit}, {31'b0, hit});
        check({nm, "_pred"}, {31'b0, br_pred_f}, {31'b0, pred});
        check({nm, "_npc"}, npc_f, npc);
    endtask

    task automatic step(input bit pw, input bit br, input logic [31:0] bpc, input bit tk,
                        input logic [31:0] tgt, input bit rd, input logic [31:0] rpc);
        PCWrite = pw; ex_branch = br; ex_pc = bpc; ex_taken = tk;
        ex_target = tgt; ex_redirect = rd; ex_redirect_pc = rpc;
        @(posedge clk);
        #1;
        PCWrite = 1'b1; ex_branch = 1'b0; ex_taken = 1'b0; ex_redirect = 1'b0;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] hi;
        int sel;
        sel = int'($urandom_range(0, 2));
        hi  = (sel == 2) ? 32'h03FF_FFFF : 32'(sel);
        return (hi << 6) | (32'($urandom_range(0, 15)) << 2)
             | (($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 3)) : 32'h0);
    endfunction

    initial begin
        rst = 1'b1;
        idle();
        rst = 1'b0;
        chk_en = 1'b1;
        exp4("reset", 32'h0, 1'b0, 1'b0, 32'h4);
        idle(); exp4("run4", 32'h4, 1'b0, 1'b0, 32'h8);
        idle(); exp4("run8", 32'h8, 1'b0, 1'b0, 32'hC);

        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
            exp4("stall", 32'h8, 1'b0, 1'b0, 32'hC);
        end
        idle(); exp4("resume", 32'hC, 1'b0, 1'b0, 32'h10);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h100);
        exp4("redir_over_stall", 32'h100, 1'b0, 1'b0, 32'h104);

        step(1'b1, 1'b1, 32'h10, 1'b1, 32'h40, 1'b1, 32'h10);
        exp4("alloc", 32'h10, 1'b1, 1'b1, 32'h40);
        idle(); exp4("follow_pred", 32'h40, 1'b0, 1'b0, 32'h44);

        step(1'b1, 1'b1, 32'h10, 1'b0, 32'h0, 1'b1, 32'h10);
        exp4("nt1", 32'h10, 1'b1, 1'b0, 32'h14);
        idle(); exp4("nt1_seq", 32'h14, 1'b0, 1'b0, 32'h18);
        step(1'b1, 1'b1, 32'h10, 1'b0, 32'h0, 1'b1, 32'h10);
        exp4("nt2", 32'h10, 1'b1, 1'b0, 32'h14);
        step(1'b1, 1'b1, 32'h10, 1'b0, 32'h0, 1'b1, 32'h10);
        exp4("nt3_floor", 32'h10, 1'b1, 1'b0, 32'h14);
        step(1'b1, 1'b1, 32'h10, 1'b1, 32'h40, 1'b1, 32'h10);
        exp4("t1", 32'h10, 1'b1, 1'b0, 32'h14);
        step(1'b1, 1'b1, 32'h10, 1'b1, 32'h40, 1'b1, 32'h10);
        exp4("t2", 32'h10, 1'b1, 1'b1, 32'h40);
        step(1'b1, 1'b1, 32'h10, 1'b1, 32'h40, 1'b1, 32'h10);
        step(1'b1, 1'b1, 32'h10, 1'b1, 32'h40, 1'b1, 32'h10);
        exp4("t4_sat", 32'h10, 1'b1, 1'b1, 32'h40);
        step(1'b1, 1'b1, 32'h10, 1'b0, 32'h0, 1'b1, 32'h10);
        exp4("sat_nt", 32'h10, 1'b1, 1'b1, 32'h40);
        step(1'b1, 1'b1, 32'h10, 1'b0, 32'h0, 1'b1, 32'h10);
        exp4("sat_nt2", 32'h10, 1'b1, 1'b0, 32'h14);

        step(1'b1, 1'b1, 32'h50, 1'b0, 32'h0, 1'b1, 32'h10);
        exp4("alias_nt", 32'h10, 1'b1, 1'b0, 32'h14);
        step(1'b1, 1'b1, 32'h50, 1'b1, 32'h80, 1'b1, 32'h10);
        exp4("alias_evict", 32'h10, 1'b0, 1'b0, 32'h14);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h50);
        exp4("alias_new", 32'h50, 1'b1, 1'b1, 32'h80);
        idle(); exp4("alias_follow", 32'h80, 1'b0, 1'b0, 32'h84);

        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        exp4("wrap_top", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
        idle(); exp4("wrap_zero", 32'h0, 1'b0, 1'b0, 32'h4);

        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h10);
        exp4("coll_before", 32'h10, 1'b0, 1'b0, 32'h14);
        step(1'b0, 1'b1, 32'h10, 1'b1, 32'h200, 1'b0, 32'h0);
        exp4("coll_after", 32'h10, 1'b1, 1'b1, 32'h200);
        idle(); exp4("coll_follow", 32'h200, 1'b0, 1'b0, 32'h204);

        for (int n = 0; n < 3000; n++) begin
            rst            = ($urandom_range(0, 299) == 0);
            PCWrite        = ($urandom_range(0, 5) != 0);
            ex_branch      = 1'($urandom_range(0, 1));
            ex_pc          = rand_pc();
            ex_taken       = 1'($urandom_range(0, 1));
            ex_target      = rand_pc();
            ex_redirect    = ($urandom_range(0, 7) == 0);
            ex_redirect_pc = rand_pc();
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        idle();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
